// File: rtl/audio_out_serializer_if.sv
// Host-side sample bus of the audio DAC serializer.
// Host writes samples; serializer reports FIFO free space.
interface audio_out_serializer_if #(
  parameter int AUDIO_DATA_WIDTH = 32
);
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data;
  logic                        left_channel_data_en;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data;
  logic                        right_channel_data_en;
  logic [7:0] left_audio_fifo_write_space;
  logic [7:0] right_audio_fifo_write_space;

  modport master (
    output left_channel_data,
    output left_channel_data_en,
    output right_channel_data,
    output right_channel_data_en,
    input  left_audio_fifo_write_space,
    input  right_audio_fifo_write_space
  );

  modport slave (
    input  left_channel_data,
    input  left_channel_data_en,
    input  right_channel_data,
    input  right_channel_data_en,
    output left_audio_fifo_write_space,
    output right_audio_fifo_write_space
  );
endinterface

// File: rtl/audio_out_serializer.sv
// Audio DAC serializer: two show-ahead sample FIFOs
// feeding an MSB-first shift register on the codec line.
module audio_out_serializer #(
  parameter int AUDIO_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 128,
  parameter int FIFO_ADDR_WIDTH  = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_clk_rising_edge,
  input  logic bit_clk_falling_edge,
  input  logic left_right_clk_rising_edge,
  input  logic left_right_clk_falling_edge,
  input  logic done_channel_sync,
  audio_out_serializer_if.slave bus,
  output logic serial_audio_out_data
);

  localparam int W  = AUDIO_DATA_WIDTH;
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  // channel 0 = left, channel 1 = right
  logic [W-1:0]  mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   used   [2];
  logic          full   [2];
  logic          empty  [2];
  logic          push   [2];
  logic          pop    [2];
  logic          wen    [2];
  logic [W-1:0]  wdata  [2];
  logic [W-1:0]  head   [2];
  logic [7:0]    space  [2];

  logic          load_l;
  logic          load_r;
  logic [W-1:0]  shift_reg;
  logic [CW-1:0] bit_cnt;

  // "bit_clk_rising_edge" is part of the codec framing but
  // data only changes on falling edges, so it is unused here
  logic unused_ok;
  assign unused_ok = bit_clk_rising_edge;

  // per-channel push/pop decisions and show-ahead heads
  always_comb begin
    wen[0]   = bus.left_channel_data_en;
    wen[1]   = bus.right_channel_data_en;
    wdata[0] = bus.left_channel_data;
    wdata[1] = bus.right_channel_data;
    load_l   = left_right_clk_rising_edge & done_channel_sync;
    load_r   = left_right_clk_falling_edge & done_channel_sync;
    for (int c = 0; c < 2; c++) begin
      full[c]  = used[c] == DEPTH;
      empty[c] = used[c] == '0;
      push[c]  = wen[c] & ~full[c];
      head[c]  = mem[c][rd_ptr[c]];
    end
    pop[0] = load_l & ~empty[0];
    pop[1] = load_r & ~empty[1];
  end

  // sample storage, written on accepted pushes
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= wdata[c];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        used[c]   <= '0;
      end else begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        unique case ({push[c], pop[c]})
          2'b10:   used[c] <= used[c] + 1'b1;
          2'b01:   used[c] <= used[c] - 1'b1;
          default: used[c] <= used[c];
        endcase
      end
    end
  end

  // registered free-space report
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset)        space[c] <= '0;
      else if (full[c]) space[c] <= '0;
      else              space[c] <= 8'(DEPTH - used[c]);
    end
  end

  assign bus.left_audio_fifo_write_space  = space[0];
  assign bus.right_audio_fifo_write_space = space[1];

  // slot load (underflow sends silence) and MSB-first shifting
  always_ff @(posedge clk) begin
    if (reset || !done_channel_sync) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load_l) begin
      shift_reg <= empty[0] ? '0 : head[0];
      bit_cnt   <= CW'(W);
    end else if (load_r) begin
      shift_reg <= empty[1] ? '0 : head[1];
      bit_cnt   <= CW'(W);
    end else if (bit_clk_falling_edge && bit_cnt != '0) begin
      shift_reg <= {shift_reg[W-2:0], 1'b0};
      bit_cnt   <= bit_cnt - 1'b1;
    end
  end

  // serial pin driver
  always_ff @(posedge clk) begin
    if (reset) serial_audio_out_data <= 1'b0;
    else       serial_audio_out_data <= shift_reg[W-1];
  end

endmodule

// File: tb/tb_audio_out_serializer.sv
// Randomized bench for audio_out_serializer against a
// queue-based model of slots, FIFOs and free space.
module tb_audio_out_serializer;

  logic clk = 1'b0;
  logic reset;
  logic bc_rise, bc_fall, lr_rise, lr_fall, sync;
  logic ser;
  logic l_en, r_en;
  logic [31:0] l_d, r_d;
  bit rnd_wr;

  int checks = 0;
  int failures = 0;

  logic [31:0] lq[$];
  logic [31:0] rq[$];
  logic [31:0] word;
  int k;
  logic exp_ser;
  logic [7:0] exp_lsp, exp_rsp;

  audio_out_serializer_if #(.AUDIO_DATA_WIDTH(32)) bus ();

  audio_out_serializer dut (
    .clk(clk),
    .reset(reset),
    .bit_clk_rising_edge(bc_rise),
    .bit_clk_falling_edge(bc_fall),
    .left_right_clk_rising_edge(lr_rise),
    .left_right_clk_falling_edge(lr_fall),
    .done_channel_sync(sync),
    .bus(bus.slave),
    .serial_audio_out_data(ser)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] space_of(input int n);
    return (n >= 128) ? 8'd0 : 8'(128 - n);
  endfunction

  // one system cycle: drive, advance model, compare
  task automatic tick();
    bit lfull, rfull;
    if (rnd_wr) begin
      l_en = ($urandom_range(0, 3) == 0);
      r_en = ($urandom_range(0, 3) == 0);
      l_d  = $urandom;
      r_d  = $urandom;
    end
    bus.left_channel_data     = l_d;
    bus.left_channel_data_en  = l_en;
    bus.right_channel_data    = r_d;
    bus.right_channel_data_en = r_en;
    @(posedge clk);
    if (reset) begin
      exp_ser = 1'b0;
      exp_lsp = 8'd0;
      exp_rsp = 8'd0;
      lq.delete();
      rq.delete();
      word = '0;
      k = 32;
    end else begin
      exp_ser = (k < 32) ? word[31-k] : 1'b0;
      exp_lsp = space_of(lq.size());
      exp_rsp = space_of(rq.size());
      lfull = lq.size() >= 128;
      rfull = rq.size() >= 128;
      if (!sync) begin
        word = '0;
        k = 32;
      end else if (lr_rise) begin
        word = (lq.size() > 0) ? lq.pop_front() : 32'd0;
        k = 0;
      end else if (lr_fall) begin
        word = (rq.size() > 0) ? rq.pop_front() : 32'd0;
        k = 0;
      end else if (bc_fall && k < 32) begin
        k++;
      end
      if (l_en && !lfull) lq.push_back(l_d);
      if (r_en && !rfull) rq.push_back(r_d);
    end
    #1;
    chk("serial", 32'(ser), 32'(exp_ser));
    chk("lspace", 32'(bus.left_audio_fifo_write_space),
        32'(exp_lsp));
    chk("rspace", 32'(bus.right_audio_fifo_write_space),
        32'(exp_rsp));
    bc_rise = 0; bc_fall = 0;
    lr_rise = 0; lr_fall = 0;
    l_en = 0; r_en = 0;
  endtask

  task automatic bclk(input int n);
    for (int i = 0; i < n; i++) begin
      bc_rise = 1; tick();
      bc_fall = 1; tick();
    end
  endtask

  // one frame; LRCK strobes coincide with a BCLK fall
  // to exercise load-over-shift priority
  task automatic frame(input int bits);
    lr_rise = 1; bc_fall = 1; tick();
    bclk(bits);
    lr_fall = 1; bc_fall = 1; tick();
    bclk(bits);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    repeat (2) tick();
  endtask

  initial begin
    reset = 1; sync = 0; rnd_wr = 0;
    bc_rise = 0; bc_fall = 0; lr_rise = 0; lr_fall = 0;
    l_en = 0; r_en = 0; l_d = '0; r_d = '0;
    word = '0; k = 32;
    do_reset();

    // known words, slot longer than the sample
    l_en = 1; l_d = 32'hA5A5_0001;
    r_en = 1; r_d = 32'h8000_0000;
    tick();
    sync = 1;
    repeat (2) tick();
    frame(34);

    // fill left, overflow write, pop, then drain in order
    for (int i = 0; i < 129; i++) begin
      l_en = 1; l_d = $urandom; tick();
    end
    repeat (2) tick();
    lr_rise = 1; tick();
    repeat (3) tick();
    repeat (130) frame(33);

    // empty FIFOs for 4 frames
    repeat (4) frame(33);

    // push with pop on a full FIFO
    for (int i = 0; i < 128; i++) begin
      l_en = 1; l_d = $urandom; tick();
    end
    repeat (2) tick();
    l_en = 1; l_d = 32'hDEAD_BEEF; lr_rise = 1; tick();
    repeat (3) tick();

    // push with pop on a half-full FIFO
    do_reset();
    for (int i = 0; i < 64; i++) begin
      l_en = 1; l_d = $urandom; tick();
    end
    repeat (2) tick();
    l_en = 1; l_d = 32'h1234_5678; lr_rise = 1; tick();
    repeat (3) tick();

    // no sync: queued words held, strobes ignored
    do_reset();
    sync = 0;
    for (int i = 0; i < 3; i++) begin
      l_en = 1; l_d = $urandom | 32'h8000_0001; tick();
    end
    repeat (3) frame(33);
    lr_rise = 1; tick();
    bclk(10);
    sync = 1;
    bclk(20);
    frame(33);

    // reset on bit 10 of a slot
    l_en = 1; l_d = 32'hFFFF_FFFF; tick();
    lr_rise = 1; tick();
    bclk(10);
    reset = 1;
    repeat (2) tick();
    reset = 0;
    repeat (3) tick();

    // randomized traffic and slot lengths
    rnd_wr = 1;
    for (int f = 0; f < 30; f++) begin
      frame($urandom_range(30, 36));
      repeat ($urandom_range(0, 4)) tick();
    end
    rnd_wr = 0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_out_serializer.md
# audio_out_serializer

Transmit-side counterpart of the audio ADC deserializer: buffers left/right DAC samples written by the host logic in two independent 128-deep FIFOs and shifts them out MSB-first on the codec's serial DAC data line, framed by the codec's bit clock and left/right clock. It sits between the audio controller's register/stream interface and the codec pins. The edge strobes come from the shared clock-edge detectors.

## Interface
- AUDIO_DATA_WIDTH, 32, sample width in bits.
- FIFO_DEPTH, 128, words per channel FIFO (power of two).
- FIFO_ADDR_WIDTH, 7, log2(FIFO_DEPTH).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- bit_clk_rising_edge  in  1  one-cycle strobe, codec BCLK rising.
- bit_clk_falling_edge  in  1  one-cycle strobe, codec BCLK falling.
- left_right_clk_rising_edge  in  1  one-cycle strobe, LRCK rising = start of left slot.
- left_right_clk_falling_edge  in  1  one-cycle strobe, LRCK falling = start of right slot.
- done_channel_sync  in  1  high once LRCK phase is locked; gates all loads.
- left_channel_data  in  AUDIO_DATA_WIDTH  left sample to enqueue.
- left_channel_data_en  in  1  enqueue left_channel_data this cycle.
- right_channel_data  in  AUDIO_DATA_WIDTH  right sample to enqueue.
- right_channel_data_en  in  1  enqueue right_channel_data this cycle.
- left_audio_fifo_write_space  out  8  free words in left FIFO (0..128), registered.
- right_audio_fifo_write_space  out  8  free words in right FIFO, registered.
- serial_audio_out_data  out  1  serial DAC data to codec, registered.

## Operation
- Per-channel FIFO: show-ahead (head word valid while not empty), FIFO_ADDR_WIDTH pointers wrapping modulo FIFO_DEPTH, full flag plus used count.
- Write: data_en & ~full pushes; data_en while full is dropped silently, no state change.
- write_space = full ? 0 : FIFO_DEPTH - used; registered each cycle.
- Load: on left_right_clk_rising_edge & done_channel_sync, shift_reg <= left head and left FIFO pops if non-empty, else shift_reg <= 0 (underflow -> silence, no pop). Same on left_right_clk_falling_edge with the right FIFO.
- Shift: on bit_clk_falling_edge (no load that cycle), shift_reg <= {shift_reg[W-2:0], 1'b0}. Bits beyond AUDIO_DATA_WIDTH in a slot are therefore 0.
- serial_audio_out_data <= shift_reg[W-1] every cycle.
- Bit counter: loaded to AUDIO_DATA_WIDTH at each load, decremented per bit_clk_falling_edge, saturates at 0. Shifts occur only while nonzero. It is observable as the slot-complete condition for verification.
- While done_channel_sync = 0: no loads, no pops, shift_reg held at 0. FIFOs still accept writes.

## Timing
- Reset: FIFOs empty, shift_reg = 0, counter = 0, both write_space = 0, serial_audio_out_data = 0. From the 2nd cycle after reset deasserts, write_space reads 128.
- Push latency: a write at cycle N is reflected in write_space at N+2.
- Pop at load cycle N: write_space increments at N+2.
- Output latency: load at cycle N -> MSB on serial_audio_out_data at N+1. Each bit_clk_falling_edge at M -> next bit at M+1, i.e. stable before the following BCLK rising edge.
- Priority: load beats a shift in the same cycle. Both LRCK strobes together are illegal and unspecified.
- Simultaneous push and pop on one FIFO: both occur, used unchanged. If full, the push is dropped and the pop still occurs.
- Pointer wrap at 127 -> 0 is transparent. Full is distinct from empty via the full flag.
- done_channel_sync rising mid-slot: the first load happens at the next LRCK strobe, with no partial word.
- Reset mid-slot: output 0 from the next cycle, buffered samples discarded.

## Test plan
- Reset, then write left 0xA5A5_0001, right 0x8000_0000, sync=1. LRCK rise, then 32 BCLK falls: serial bits = 0xA5A5_0001 MSB-first, then 0. LRCK fall: 1 followed by 31 zeros.
- Write 128 left words: write_space goes 128 -> 0. The 129th write is dropped. After one LRCK rise (pop), write_space reads 1 two cycles later. Check order by draining all 128 values.
- Empty FIFOs with sync=1 over 4 frames: output constantly 0, write_space stays 128, no pointer movement.
- Push and LRCK-rise pop in the same cycle on a full left FIFO: push ignored, write_space = 1. Push and pop on a half-full FIFO: write_space unchanged.
- sync=0 with 3 words queued and LRCK strobes toggling: output 0, write_space = 125. Raise sync mid-slot: first data appears after the next LRCK rise.
- Assert reset on bit 10 of a slot: output 0 the next cycle. write_space reads 0 during reset and 128 two cycles after release.
